seg_display_bcd: RTL and testbench



---
 rtl/seg_display_bcd_if.sv | 18 +
 rtl/seg_display_bcd.sv | 170 +++++++++++++++++
 tb/tb_seg_display_bcd.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_bcd_if.sv
// ============================================================================
//  seg_display_bcd_if : value-in valid/ready handshake for seg_display_bcd
//  Rev 1.0
// ============================================================================
`default_nettype none

interface seg_display_bcd_if #(
    parameter int BIN_W = 12
) ();
    logic [BIN_W-1:0] din;
    logic             din_val;
    logic             din_rdy;

    modport master (output din, output din_val, input  din_rdy);
    modport slave  (input  din, input  din_val, output din_rdy);
endinterface

`default_nettype wire

// File: rtl/seg_display_bcd.sv
// ============================================================================
//  seg_display_bcd : binary-to-BCD (double dabble) multiplexed 7-seg driver
//  Rev 1.0
// ============================================================================
`default_nettype none

module seg_display_bcd #(
    parameter int BIN_W    = 12,
    parameter int DIGITS   = 6,
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int DP_POS   = 1,
    parameter int BLANK_LZ = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    seg_display_bcd_if.slave       s_in,
    output logic                   ovf,
    output logic [DIGITS-1:0]      seg_sel,
    output logic [7:0]             seg_data
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam int          c_bcd_w   = 4 * DIGITS;
    localparam int          c_dwell   = CLK_HZ / SCAN_HZ;
    localparam int          c_dwell_w = (c_dwell > 2) ? $clog2(c_dwell) : 1;
    localparam int          c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          c_cnt_w   = $clog2(BIN_W);
    localparam logic [63:0] c_max_val = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [BIN_W-1:0]     bin_q,      bin_d;
    logic [c_bcd_w-1:0]   bcd_q,      bcd_d;
    logic [c_bcd_w-1:0]   bcd_adj;
    logic [c_cnt_w-1:0]   cnt_q,      cnt_d;
    logic                 ovf_next_q, ovf_next_d;
    logic [c_bcd_w-1:0]   disp_q,     disp_d;
    logic                 ovf_q,      ovf_d;
    logic [c_dwell_w-1:0] dwell_q,    dwell_d;
    logic [c_idx_w-1:0]   idx_q,      idx_d;
    logic [DIGITS-1:0]    seg_sel_q,  seg_sel_d;
    logic [7:0]           seg_data_q, seg_data_d;

    logic [3:0]           nibble;
    logic                 upper_zero;
    logic                 blank;

    assign s_in.din_rdy = (state_q == ST_IDLE);
    assign ovf          = ovf_q;
    assign seg_sel      = seg_sel_q;
    assign seg_data     = seg_data_q;

    // Converter: load, BIN_W add-3/shift iterations, then commit to display
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        bcd_adj    = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        case (state_q)
            ST_IDLE: begin
                if (s_in.din_val) begin
                    bin_d      = s_in.din;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_next_d = (64'(s_in.din) > c_max_val);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = {bcd_adj[c_bcd_w-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (int'(cnt_q) == BIN_W - 1) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                disp_d  = bcd_q;
                ovf_d   = ovf_next_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan and per-digit decode; outputs registered against the current index
    always_comb begin
        dwell_d = dwell_q + 1'b1;
        idx_d   = idx_q;
        if (int'(dwell_q) == c_dwell - 1) begin
            dwell_d = '0;
            idx_d   = (int'(idx_q) == DIGITS - 1) ? '0 : idx_q + 1'b1;
        end

        nibble     = 4'd0;
        upper_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (j == int'(idx_q)) nibble = disp_q[4*j +: 4];
            if ((j >= int'(idx_q)) && (disp_q[4*j +: 4] != 4'd0)) upper_zero = 1'b0;
        end
        blank = (BLANK_LZ != 0) && (int'(idx_q) > 0) && (int'(idx_q) > DP_POS) && upper_zero;

        case (nibble)
            4'd0:    seg_data_d = 8'hC0;
            4'd1:    seg_data_d = 8'hF9;
            4'd2:    seg_data_d = 8'hA4;
            4'd3:    seg_data_d = 8'hB0;
            4'd4:    seg_data_d = 8'h99;
            4'd5:    seg_data_d = 8'h92;
            4'd6:    seg_data_d = 8'h82;
            4'd7:    seg_data_d = 8'hF8;
            4'd8:    seg_data_d = 8'h80;
            4'd9:    seg_data_d = 8'h90;
            default: seg_data_d = 8'hFF;
        endcase
        if (blank) seg_data_d = 8'hFF;
        if ((seg_data_d != 8'hFF) && (int'(idx_q) == DP_POS)) seg_data_d[7] = 1'b0;
        if (ovf_q) seg_data_d = 8'hBF;

        seg_sel_d = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            dwell_q    <= '0;
            idx_q      <= '0;
            seg_sel_q  <= '1;
            seg_data_q <= 8'hFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            dwell_q    <= dwell_d;
            idx_q      <= idx_d;
            seg_sel_q  <= seg_sel_d;
            seg_data_q <= seg_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_bcd.sv
// ============================================================================
//  tb_seg_display_bcd : directed self-checking bench, dwell of 10 cycles
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int bad_sel = 0;

    seg_display_bcd_if #(.BIN_W(12)) if_main ();
    seg_display_bcd_if #(.BIN_W(12)) if_nolz ();
    seg_display_bcd_if #(.BIN_W(12)) if_d3 ();

    logic       ovf_main, ovf_nolz, ovf_d3;
    logic [5:0] sel_main, sel_nolz;
    logic [2:0] sel_d3;
    logic [7:0] dat_main, dat_nolz, dat_d3;

    seg_display_bcd #(.BIN_W(12), .DIGITS(6), .CLK_HZ(1000), .SCAN_HZ(100),
                      .DP_POS(1), .BLANK_LZ(1)) u_main (
        .clk(clk), .rst(rst), .s_in(if_main), .ovf(ovf_main),
        .seg_sel(sel_main), .seg_data(dat_main));

    seg_display_bcd #(.BIN_W(12), .DIGITS(6), .CLK_HZ(1000), .SCAN_HZ(100),
                      .DP_POS(1), .BLANK_LZ(0)) u_nolz (
        .clk(clk), .rst(rst), .s_in(if_nolz), .ovf(ovf_nolz),
        .seg_sel(sel_nolz), .seg_data(dat_nolz));

    seg_display_bcd #(.BIN_W(12), .DIGITS(3), .CLK_HZ(1000), .SCAN_HZ(100),
                      .DP_POS(1), .BLANK_LZ(1)) u_d3 (
        .clk(clk), .rst(rst), .s_in(if_d3), .ovf(ovf_d3),
        .seg_sel(sel_d3), .seg_data(dat_d3));

    // Latest pattern seen on each physical digit
    logic [7:0] sh_main [6];
    logic [7:0] sh_nolz [6];
    logic [7:0] sh_d3   [3];

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (sel_main == ~(6'd1 << i)) sh_main[i] <= dat_main;
            if (sel_nolz == ~(6'd1 << i)) sh_nolz[i] <= dat_nolz;
        end
        for (int i = 0; i < 3; i++) begin
            if (sel_d3 == ~(3'd1 << i)) sh_d3[i] <= dat_d3;
        end
        if (!rst && sel_main != 6'h3F && $countones(~sel_main) != 1) bad_sel <= bad_sel + 1;
    end

    task automatic wait_frames();
        repeat (140) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_main(input string name, input logic [7:0] e0, e1, e2, e3, e4, e5);
        logic [7:0] ex [6];
        ex = '{e0, e1, e2, e3, e4, e5};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (sh_main[i] !== ex[i]) begin
                n_err++;
                $display("FAIL %s digit %0d: got %h expected %h", name, i, sh_main[i], ex[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_main.din = '0; if_main.din_val = 1'b0;
        if_nolz.din = '0; if_nolz.din_val = 1'b0;
        if_d3.din   = '0; if_d3.din_val   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sel_main !== 6'h3F || dat_main !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_outputs: got sel=%h data=%h expected sel=3f data=ff", sel_main, dat_main);
        end
        n_cmp++;
        if (if_main.din_rdy !== 1'b1 || ovf_main !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rdy_ovf: got rdy=%b ovf=%b expected rdy=1 ovf=0", if_main.din_rdy, ovf_main);
        end
        rst = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (sel_main !== 6'h3E || dat_main !== 8'hC0) begin
                n_err++;
                $display("FAIL reset_dwell0 cycle %0d: got sel=%h data=%h expected sel=3e data=c0", k, sel_main, dat_main);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (sel_main !== 6'h3D || dat_main !== 8'h40) begin
            n_err++;
            $display("FAIL reset_dwell1: got sel=%h data=%h expected sel=3d data=40", sel_main, dat_main);
        end
        wait_frames();
        check_main("reset_frame", 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    endtask

    task automatic test_convert();
        int lows;
        @(negedge clk);
        if_main.din = 12'd1234; if_main.din_val = 1'b1;
        @(posedge clk); #1;
        if_main.din_val = 1'b0;
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_main.din_rdy === 1'b1) break;
            lows++;
        end
        n_cmp++;
        if (lows != 13) begin
            n_err++;
            $display("FAIL convert_busy_cycles: got %0d expected 13", lows);
        end
        wait_frames();
        check_main("convert_1234", 8'h99, 8'h30, 8'hA4, 8'hF9, 8'hFF, 8'hFF);
        n_cmp++;
        if (ovf_main !== 1'b0) begin
            n_err++;
            $display("FAIL convert_ovf: got %b expected 0", ovf_main);
        end
    endtask

    task automatic test_blank();
        logic [7:0] ex [6];
        @(negedge clk);
        if_main.din = 12'd5; if_main.din_val = 1'b1;
        if_nolz.din = 12'd5; if_nolz.din_val = 1'b1;
        @(posedge clk); #1;
        if_main.din_val = 1'b0;
        if_nolz.din_val = 1'b0;
        wait_frames();
        check_main("blank_5", 8'h92, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        ex = '{8'h92, 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (sh_nolz[i] !== ex[i]) begin
                n_err++;
                $display("FAIL noblank_5 digit %0d: got %h expected %h", i, sh_nolz[i], ex[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ex [3];
        @(negedge clk);
        if_d3.din = 12'd999; if_d3.din_val = 1'b1;
        @(posedge clk); #1;
        if_d3.din_val = 1'b0;
        wait_frames();
        ex = '{8'h90, 8'h10, 8'h90};
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sh_d3[i] !== ex[i]) begin
                n_err++;
                $display("FAIL d3_999 digit %0d: got %h expected %h", i, sh_d3[i], ex[i]);
            end
        end
        n_cmp++;
        if (ovf_d3 !== 1'b0) begin
            n_err++;
            $display("FAIL d3_999_ovf: got %b expected 0", ovf_d3);
        end
        @(negedge clk);
        if_d3.din = 12'd1000; if_d3.din_val = 1'b1;
        @(posedge clk); #1;
        if_d3.din_val = 1'b0;
        wait_frames();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sh_d3[i] !== 8'hBF) begin
                n_err++;
                $display("FAIL d3_1000 digit %0d: got %h expected bf", i, sh_d3[i]);
            end
        end
        n_cmp++;
        if (ovf_d3 !== 1'b1) begin
            n_err++;
            $display("FAIL d3_1000_ovf: got %b expected 1", ovf_d3);
        end
    endtask

    task automatic test_back_to_back();
        int lows;
        @(negedge clk);
        if_main.din = 12'd1234; if_main.din_val = 1'b1;
        @(posedge clk); #1;
        if_main.din = 12'd77;
        lows = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_main.din_rdy === 1'b1) break;
            lows++;
        end
        n_cmp++;
        if (lows != 13) begin
            n_err++;
            $display("FAIL b2b_first_busy: got %0d expected 13", lows);
        end
        @(negedge clk);
        n_cmp++;
        if (if_main.din_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_accept: got rdy=%b expected 0", if_main.din_rdy);
        end
        lows = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_main.din_rdy === 1'b1) break;
            lows++;
        end
        if_main.din_val = 1'b0;
        n_cmp++;
        if (lows != 13) begin
            n_err++;
            $display("FAIL b2b_second_busy: got %0d expected 13", lows);
        end
        wait_frames();
        check_main("b2b_77", 8'hF8, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if_main.din = 12'd4095; if_main.din_val = 1'b1;
        @(posedge clk); #1;
        if_main.din_val = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (if_main.din_rdy !== 1'b1 || ovf_main !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_rdy: got rdy=%b ovf=%b expected rdy=1 ovf=0", if_main.din_rdy, ovf_main);
        end
        wait_frames();
        check_main("midrst_frame", 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        n_cmp++;
        if (if_main.din_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_idle: got rdy=%b expected 1", if_main.din_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blank();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (bad_sel != 0) begin
            n_err++;
            $display("FAIL seg_sel_onehot: got %0d bad cycles expected 0", bad_sel);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
